// File: rtl/rio_link_rx_sync.sv
// RapidIO lane synchroniser: classifies aligned 8b/10b words, runs LOSS/ACQ/SYNC
// acquisition, filters idles and forwards live link data with one cycle of latency.
module rio_link_rx_sync #(
   parameter logic [7:0] RIO_COMMA_CHAR = 8'hbc,
   parameter logic [7:0] RIO_SKIP_CHAR  = 8'h1c,
   parameter int         SYNC_CNT       = 16,
   parameter int         ERR_LIMIT      = 4,
   parameter int         ERR_WINDOW     = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] i_rio_rx_data,
   input  logic [1:0]  i_rio_rx_isk,
   input  logic        i_force_resync,
   output logic [15:0] o_rio_rx_data,
   output logic [1:0]  o_rio_rx_isk,
   output logic        o_rio_rx_valid,
   output logic        o_sync,
   output logic        o_err,
   output logic [7:0]  o_loss_cnt
);

   typedef enum logic [1:0] {ST_LOSS, ST_ACQ, ST_SYNC} state_t;

   localparam logic [4:0]  SYNC_TGT = 5'(SYNC_CNT);
   localparam logic [3:0]  ERR_TGT  = 4'(ERR_LIMIT);
   localparam logic [15:0] WIN_TGT  = 16'(ERR_WINDOW);

   state_t      state;
   logic [4:0]  ccnt;
   logic [3:0]  ecnt;
   logic [15:0] wcnt;
   logic [7:0]  loss_cnt;

   logic [15:0] data_p1;
   logic [1:0]  isk_p1;
   logic        vld_p1;
   logic        err_p1;

   logic [7:0]  lo_byte;
   logic [7:0]  hi_byte;
   logic        err_w;
   logic        comma_w;
   logic        idle_w;

   function automatic logic is_legal_k(input logic [7:0] b);
      return (b == 8'h1c) || (b == 8'h3c) || (b == 8'h7c) || (b == 8'hbc) ||
             (b == 8'hfb) || (b == 8'hfd) || (b == 8'hfe);
   endfunction

   function automatic logic is_idle_byte(input logic [7:0] b);
      return (b == RIO_COMMA_CHAR) || (b == RIO_SKIP_CHAR);
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hff) ? v : v + 8'd1;
   endfunction

   assign lo_byte = i_rio_rx_data[7:0];
   assign hi_byte = i_rio_rx_data[15:8];

   // A comma in the second byte is only misaligned when the first byte is not already a comma.
   assign err_w   = (i_rio_rx_isk[0] & ~is_legal_k(lo_byte)) |
                    (i_rio_rx_isk[1] & ~is_legal_k(hi_byte)) |
                    (i_rio_rx_isk[1] & (hi_byte == RIO_COMMA_CHAR) &
                     ~(i_rio_rx_isk[0] & (lo_byte == RIO_COMMA_CHAR)));
   assign comma_w = i_rio_rx_isk[0] & (lo_byte == RIO_COMMA_CHAR) & ~err_w;
   assign idle_w  = (i_rio_rx_isk == 2'b11) & is_idle_byte(lo_byte) &
                    is_idle_byte(hi_byte) & ~err_w;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_LOSS;
         ccnt     <= '0;
         ecnt     <= '0;
         wcnt     <= '0;
         loss_cnt <= '0;
      end else if (i_force_resync) begin
         state <= ST_LOSS;
         ccnt  <= '0;
         if (state == ST_SYNC) loss_cnt <= sat_inc8(loss_cnt);
      end else begin
         case (state)
            ST_LOSS: begin
               if (comma_w) begin
                  if (SYNC_TGT == 5'd1) begin
                     state <= ST_SYNC;
                     ecnt  <= '0;
                     wcnt  <= '0;
                  end else begin
                     state <= ST_ACQ;
                     ccnt  <= 5'd1;
                  end
               end
            end
            ST_ACQ: begin
               if (err_w) begin
                  state <= ST_LOSS;
                  ccnt  <= '0;
               end else if (comma_w) begin
                  if (ccnt + 5'd1 == SYNC_TGT) begin
                     state <= ST_SYNC;
                     ecnt  <= '0;
                     wcnt  <= '0;
                  end else begin
                     ccnt <= ccnt + 5'd1;
                  end
               end
            end
            ST_SYNC: begin
               // An error restarts the clean window, so it can never coincide with a retirement.
               if (err_w) begin
                  wcnt <= '0;
                  if (ecnt + 4'd1 == ERR_TGT) begin
                     state    <= ST_LOSS;
                     ccnt     <= '0;
                     loss_cnt <= sat_inc8(loss_cnt);
                  end else begin
                     ecnt <= ecnt + 4'd1;
                  end
               end else if (wcnt + 16'd1 == WIN_TGT) begin
                  wcnt <= '0;
                  if (ecnt != 4'd0) ecnt <= ecnt - 4'd1;
               end else begin
                  wcnt <= wcnt + 16'd1;
               end
            end
            default: state <= ST_LOSS;
         endcase
      end
   end

   // Stage p1: registered forwarding of the sampled word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_p1 <= '0;
         isk_p1  <= '0;
         vld_p1  <= 1'b0;
         err_p1  <= 1'b0;
      end else begin
         data_p1 <= i_rio_rx_data;
         isk_p1  <= i_rio_rx_isk;
         vld_p1  <= (state == ST_SYNC) & ~idle_w & ~err_w & ~i_force_resync;
         err_p1  <= err_w;
      end
   end

   assign o_rio_rx_data  = data_p1;
   assign o_rio_rx_isk   = isk_p1;
   assign o_rio_rx_valid = vld_p1;
   assign o_err          = err_p1;
   assign o_sync         = (state == ST_SYNC);
   assign o_loss_cnt     = loss_cnt;

endmodule

// File: tb/tb_rio_link_rx_sync.sv
// Directed bench for rio_link_rx_sync: acquisition, abort, error leak and loss,
// forwarding/idle filtering, forced resync and asynchronous reset.
module tb_rio_link_rx_sync;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] rx_data = '0;
   logic [1:0]  rx_isk = '0;
   logic        force_resync = 1'b0;
   logic [15:0] o_data;
   logic [1:0]  o_isk;
   logic        o_valid;
   logic        o_sync;
   logic        o_err;
   logic [7:0]  o_loss_cnt;

   int checks = 0;
   int failures = 0;
   int pulses;

   localparam logic [15:0] COMMA_W = 16'hbcbc;
   localparam logic [15:0] BAD_W   = 16'h0055;

   rio_link_rx_sync dut (
      .clk            (clk),
      .rst            (rst),
      .i_rio_rx_data  (rx_data),
      .i_rio_rx_isk   (rx_isk),
      .i_force_resync (force_resync),
      .o_rio_rx_data  (o_data),
      .o_rio_rx_isk   (o_isk),
      .o_rio_rx_valid (o_valid),
      .o_sync         (o_sync),
      .o_err          (o_err),
      .o_loss_cnt     (o_loss_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a word, let one edge sample it, then settle past the edge.
   task automatic drive(input logic [15:0] d, input logic [1:0] k);
      rx_data = d;
      rx_isk  = k;
      @(posedge clk);
      #1;
   endtask

   task automatic commas(input int n);
      for (int i = 0; i < n; i++) drive(COMMA_W, 2'b11);
   endtask

   task automatic clean(input int n);
      for (int i = 0; i < n; i++) drive(16'h1234, 2'b00);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #3;
      check("rst_sync", o_sync, 0);
      check("rst_loss", o_loss_cnt, 0);
      check("rst_valid", o_valid, 0);
      check("rst_err", o_err, 0);
      check("rst_data", {o_isk, o_data}, 0);
      #20 rst = 1'b0;

      // Acquisition
      commas(15);
      check("acq15_sync", o_sync, 0);
      check("acq15_valid", o_valid, 0);
      commas(1);
      check("acq16_sync", o_sync, 1);
      check("acq16_valid", o_valid, 0);
      commas(1);
      check("sync_comma_valid", o_valid, 0);

      // Forwarding and idle filtering
      drive(16'h1234, 2'b00);
      check("fwd_data", o_data, 16'h1234);
      check("fwd_valid", o_valid, 1);
      drive(16'h1cbc, 2'b11);
      check("idle_valid", o_valid, 0);
      check("idle_isk", o_isk, 2'b11);
      drive(16'h127c, 2'b01);
      check("k7c_valid", o_valid, 1);
      check("k7c_err", o_err, 0);
      drive(16'h00bc, 2'b10);
      check("misalign_err", o_err, 1);
      check("misalign_valid", o_valid, 0);
      clean(300);

      // Error leak: isolated errors retire before the next one arrives
      for (int e = 0; e < 20; e++) begin
         drive(BAD_W, 2'b01);
         clean(299);
      end
      check("leak_sync", o_sync, 1);
      check("leak_loss", o_loss_cnt, 0);

      // Sync loss: four errors ten cycles apart
      pulses = 0;
      for (int e = 0; e < 4; e++) begin
         if (e > 0) begin
            for (int c = 0; c < 9; c++) begin
               drive(16'h1234, 2'b00);
               pulses += int'(o_err);
            end
         end
         drive(BAD_W, 2'b01);
         pulses += int'(o_err);
         if (e == 2) check("loss3_sync", o_sync, 1);
      end
      check("loss4_sync", o_sync, 0);
      check("loss4_cnt", o_loss_cnt, 1);
      check("loss4_pulses", pulses, 4);

      // Acquisition abort
      commas(10);
      drive(BAD_W, 2'b01);
      check("abort_err", o_err, 1);
      check("abort_sync", o_sync, 0);
      commas(15);
      check("abort15_sync", o_sync, 0);
      commas(1);
      check("abort16_sync", o_sync, 1);

      // Window boundary: 256 clean cycles retire one error, 255 do not
      drive(BAD_W, 2'b01);
      drive(BAD_W, 2'b01);
      drive(BAD_W, 2'b01);
      clean(256);
      drive(BAD_W, 2'b01);
      check("win256_sync", o_sync, 1);
      clean(255);
      drive(BAD_W, 2'b01);
      check("win255_sync", o_sync, 0);
      check("win255_loss", o_loss_cnt, 2);

      // Forced resync
      commas(16);
      check("reacq_sync", o_sync, 1);
      force_resync = 1'b1;
      drive(16'h1234, 2'b00);
      force_resync = 1'b0;
      check("force_sync", o_sync, 0);
      check("force_loss", o_loss_cnt, 3);
      check("force_valid", o_valid, 0);
      drive(16'h1234, 2'b00);
      check("presync_valid", o_valid, 0);
      drive(16'h127c, 2'b01);
      check("presync_k_valid", o_valid, 0);

      // Asynchronous reset between edges
      commas(16);
      drive(16'h5678, 2'b00);
      check("pre_rst_valid", o_valid, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_sync", o_sync, 0);
      check("arst_valid", o_valid, 0);
      check("arst_loss", o_loss_cnt, 0);
      check("arst_data", {o_isk, o_data}, 0);
      #1 rst = 1'b0;
      commas(15);
      check("post_rst15_sync", o_sync, 0);
      commas(1);
      check("post_rst16_sync", o_sync, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
